// File: rtl/reaction_pkg.sv
// ----------------------------------------------------------------------------
// reaction_pkg
// Shared definitions for the reaction trial controller:
//   - state_t     : trial FSM states (2 bits)
//   - DEFAULT_MAX_MS : default saturation / timeout value of the reaction count
//   - RAND_W, MS_W, DELAY_W : widths of the random word, the millisecond
//     result and the pre-"go" delay counter
// ----------------------------------------------------------------------------
package reaction_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_DELAY = 2'd1,
        MEASURE    = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam int DEFAULT_MAX_MS = 9999;
    localparam int RAND_W         = 12;
    localparam int MS_W           = 14;
    // MIN_DELAY_MS + a 12-bit random word fits in 13 bits for the defaults.
    localparam int DELAY_W        = 13;

endpackage

// File: rtl/ms_tick_gen.sv
// ----------------------------------------------------------------------------
// ms_tick_gen
// Millisecond tick divider. Counts 0..TICK_DIV-1 and asserts tick while the
// count is TICK_DIV-1. A clr pulse restarts the count, so the first tick after
// a clear is seen exactly TICK_DIV cycles later.
//
// Parameters: TICK_DIV - clock cycles per tick (>= 2)
// Ports:
//   clk   in   clock
//   rst_n in   asynchronous active-low reset
//   clr   in   synchronous restart of the divider
//   tick  out  one-cycle pulse every TICK_DIV cycles
// ----------------------------------------------------------------------------
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr || (cnt_reg == CNT_LAST)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/reaction_trial_ctrl.sv
// ----------------------------------------------------------------------------
// reaction_trial_ctrl
// One timed reaction trial: a start press samples the LFSR word, waits
// MIN_DELAY_MS + random_num ms, opens the "go" window and counts ms until the
// reaction press. Presses before the window are flagged early.
//
// Build option: REACTION_TIMEOUT_EN
//   defined   - reaching MAX_MS in MEASURE ends the trial with timeout=1
//   undefined - the count saturates at MAX_MS and waits for a press;
//               timeout is never set
//
// Parameters: TICK_DIV (cycles per ms), MIN_DELAY_MS, MAX_MS
// Ports:
//   CLK_50MHZ    in   clock
//   RESET_N      in   asynchronous active-low reset
//   random_num   in   [11:0] random word, sampled on the start edge only
//   start_btn    in   debounced level, rising edge starts a trial
//   react_btn    in   debounced level, rising edge is the reaction
//   led_go       out  reaction window open
//   busy         out  not idle
//   result_valid out  one-cycle pulse when a trial ends
//   reaction_ms  out  [13:0] measured ms, held until the next start
//   early        out  last trial ended with a press before led_go
//   timeout      out  last trial hit MAX_MS
// ----------------------------------------------------------------------------
module reaction_trial_ctrl
    import reaction_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int MAX_MS       = DEFAULT_MAX_MS
) (
    input  logic              CLK_50MHZ,
    input  logic              RESET_N,
    input  logic [RAND_W-1:0] random_num,
    input  logic              start_btn,
    input  logic              react_btn,
    output logic              led_go,
    output logic              busy,
    output logic              result_valid,
    output logic [MS_W-1:0]   reaction_ms,
    output logic              early,
    output logic              timeout
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_WAIT    = WAIT_DELAY;
    localparam logic [1:0] ST_MEASURE = MEASURE;
    localparam logic [1:0] ST_DONE    = DONE;

    localparam logic [MS_W-1:0]    MS_MAX    = MS_W'(MAX_MS);
    localparam logic [DELAY_W-1:0] DELAY_MIN = DELAY_W'(MIN_DELAY_MS);

    // ------------------------------------------------------------------
    // Button edge detection. Both stages reset to 1 so that a button held
    // through reset does not look like a fresh press.
    // ------------------------------------------------------------------
    logic [1:0] btn_in;
    logic [1:0] btn_edge;
    logic       start_edge;
    logic       react_edge;

    assign btn_in = {react_btn, start_btn};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            logic cur_reg;
            logic prev_reg;

            always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
                if (!RESET_N) begin
                    cur_reg  <= 1'b1;
                    prev_reg <= 1'b1;
                end else begin
                    cur_reg  <= btn_in[gi];
                    prev_reg <= cur_reg;
                end
            end

            assign btn_edge[gi] = cur_reg & ~prev_reg;
        end
    endgenerate

    assign start_edge = btn_edge[0];
    assign react_edge = btn_edge[1];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]         state_reg,   state_next;
    logic [DELAY_W-1:0] delay_reg,   delay_next;
    logic [MS_W-1:0]    ms_reg,      ms_next;
    logic [MS_W-1:0]    ms_inc;
    logic               early_reg,   early_next;
    logic               timeout_reg, timeout_next;
    logic               tick;
    logic               tick_clr;

    // The divider restarts on every state change so each state's first
    // tick lands a full period after entry.
    assign tick_clr = (state_next != state_reg);

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (CLK_50MHZ),
        .rst_n (RESET_N),
        .clr   (tick_clr),
        .tick  (tick)
    );

    // Saturating millisecond count used while the window is open.
    assign ms_inc = (tick && (ms_reg < MS_MAX)) ? ms_reg + MS_W'(1) : ms_reg;

    always_comb begin
        state_next   = state_reg;
        delay_next   = delay_reg;
        ms_next      = ms_reg;
        early_next   = early_reg;
        timeout_next = timeout_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start_edge) begin
                    delay_next   = DELAY_MIN + DELAY_W'(random_num);
                    ms_next      = '0;
                    early_next   = 1'b0;
                    timeout_next = 1'b0;
                    state_next   = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // A press wins over the final delay tick: still early.
                if (react_edge) begin
                    early_next = 1'b1;
                    ms_next    = '0;
                    state_next = ST_DONE;
                end else if (tick) begin
                    if (delay_reg <= DELAY_W'(1)) begin
                        state_next = ST_MEASURE;
                    end else begin
                        delay_next = delay_reg - DELAY_W'(1);
                    end
                end
            end

            ST_MEASURE: begin
                // A tick coinciding with the press is still counted.
                ms_next = ms_inc;
                if (react_edge) begin
                    state_next = ST_DONE;
                end
`ifdef REACTION_TIMEOUT_EN
                else if (ms_inc >= MS_MAX) begin
                    ms_next      = MS_MAX;
                    timeout_next = 1'b1;
                    state_next   = ST_DONE;
                end
`endif
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg   <= ST_IDLE;
            delay_reg   <= '0;
            ms_reg      <= '0;
            early_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            delay_reg   <= delay_next;
            ms_reg      <= ms_next;
            early_reg   <= early_next;
            timeout_reg <= timeout_next;
        end
    end

    // Status outputs decode the state register directly so they follow
    // an asynchronous reset without waiting for a clock edge.
    assign led_go       = (state_reg == ST_MEASURE);
    assign busy         = (state_reg != ST_IDLE);
    assign result_valid = (state_reg == ST_DONE);
    assign reaction_ms  = ms_reg;
    assign early        = early_reg;
    assign timeout      = timeout_reg;

endmodule

// File: tb/tb_reaction_trial_ctrl.sv
`timescale 1ns/1ps
module tb_reaction_trial_ctrl;

    localparam int TICK_DIV = 4;
    localparam int MIN_DLY  = 2;
    localparam int W_BUSY   = 0;
    localparam int W_LED    = 1;
    localparam int W_RV     = 2;

    logic        CLK_50MHZ = 1'b0;
    logic        RESET_N;
    logic [11:0] random_num;
    logic        start_btn;
    logic        react_btn;
    logic        led_go;
    logic        busy;
    logic        result_valid;
    logic [13:0] reaction_ms;
    logic        early;
    logic        timeout;

    always #5 CLK_50MHZ = ~CLK_50MHZ;

    reaction_trial_ctrl #(
        .TICK_DIV     (TICK_DIV),
        .MIN_DELAY_MS (MIN_DLY),
        .MAX_MS       (9)
    ) dut (
        .CLK_50MHZ    (CLK_50MHZ),
        .RESET_N      (RESET_N),
        .random_num   (random_num),
        .start_btn    (start_btn),
        .react_btn    (react_btn),
        .led_go       (led_go),
        .busy         (busy),
        .result_valid (result_valid),
        .reaction_ms  (reaction_ms),
        .early        (early),
        .timeout      (timeout)
    );

    typedef struct packed {
        logic [13:0] ms;
        logic        early;
        logic        timeout;
    } result_t;

    result_t sb[$];
    int      vectors      = 0;
    int      miscompares  = 0;
    int      result_count = 0;
    bit      led_seen     = 1'b0;

    // Result monitor: every result_valid pulse is matched against the
    // oldest expected result.
    always @(negedge CLK_50MHZ) begin
        result_t exp_r;
        if (RESET_N && led_go) led_seen = 1'b1;
        if (RESET_N && result_valid) begin
            result_count++;
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_result observed ms=%0d early=%0b timeout=%0b expected no result",
                       reaction_ms, early, timeout);
            end
            if (sb.size() != 0) begin
                exp_r = sb.pop_front();
                vectors++;
                assert ({reaction_ms, early, timeout} === exp_r) else begin
                    miscompares++;
                    $error("FAIL result observed ms=%0d early=%0b timeout=%0b expected ms=%0d early=%0b timeout=%0b",
                           reaction_ms, early, timeout, exp_r.ms, exp_r.early, exp_r.timeout);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            W_BUSY:  return busy;
            W_LED:   return led_go;
            default: return result_valid;
        endcase
    endfunction

    // Bounded wait: returns the number of negedges waited (== budget on expiry).
    task automatic wait_until(input int which, input int budget, output int n);
        n = 0;
        while (sel(which) !== 1'b1 && n < budget) begin
            @(negedge CLK_50MHZ);
            n++;
        end
    endtask

    // Drives a start press and returns at the first negedge with busy high.
    task automatic start_trial(input logic [11:0] rnd);
        int n;
        random_num = rnd;
        start_btn  = 1'b1;
        wait_until(W_BUSY, 10, n);
        check("busy_latency", n, 2);
        random_num = 12'hFFF;   // only the start-edge value may matter
        start_btn  = 1'b0;
    endtask

    task automatic wait_led(input int rnd);
        int n;
        wait_until(W_LED, 200, n);
        check("led_delay", n, (MIN_DLY + rnd) * TICK_DIV);
    endtask

    task automatic react_finish(input result_t exp_r, input string tag);
        int n;
        int rc0;
        sb.push_back(exp_r);
        rc0 = result_count;
        react_btn = 1'b1;
        wait_until(W_RV, 10, n);
        check({tag, "_rv_latency"}, n, 2);
        @(negedge CLK_50MHZ);
        react_btn = 1'b0;
        check({tag, "_idle_after"}, busy, 0);
        repeat (2) @(negedge CLK_50MHZ);
        check({tag, "_one_pulse"}, result_count, rc0 + 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0;
        RESET_N    = 1'b0;
        start_btn  = 1'b0;
        react_btn  = 1'b0;
        random_num = '0;
        repeat (3) @(negedge CLK_50MHZ);
        check("rst_led_go", led_go, 0);
        check("rst_busy", busy, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_reaction_ms", reaction_ms, 0);
        check("rst_early", early, 0);
        check("rst_timeout", timeout, 0);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK_50MHZ);
        check("idle_busy", busy, 0);

        // Normal trial: 5 ms of reaction time.
        start_trial(12'd3);
        wait_led(3);
        repeat (20) @(negedge CLK_50MHZ);
        react_finish('{ms: 14'd5, early: 1'b0, timeout: 1'b0}, "t1");
        check("t1_held_ms", reaction_ms, 5);

        // Early press during the delay.
        led_seen = 1'b0;
        start_trial(12'd1);
        check("t2_ms_cleared", reaction_ms, 0);
        repeat (3) @(negedge CLK_50MHZ);
        react_finish('{ms: 14'd0, early: 1'b1, timeout: 1'b0}, "t2");
        check("t2_no_led", led_seen, 0);
        check("t2_early_held", early, 1);

        // Start press during MEASURE is ignored.
        start_trial(12'd3);
        check("t4_early_cleared", early, 0);
        wait_led(3);
        repeat (4) @(negedge CLK_50MHZ);
        start_btn = 1'b1;
        repeat (3) @(negedge CLK_50MHZ);
        check("t4_busy", busy, 1);
        check("t4_led", led_go, 1);
        start_btn = 1'b0;
        repeat (13) @(negedge CLK_50MHZ);
        react_finish('{ms: 14'd5, early: 1'b0, timeout: 1'b0}, "t4");
        repeat (4) @(negedge CLK_50MHZ);
        check("t4_no_restart", busy, 0);

        // Press coincident with the final delay tick counts as early.
        led_seen = 1'b0;
        start_trial(12'd3);
        repeat (18) @(negedge CLK_50MHZ);
        react_finish('{ms: 14'd0, early: 1'b1, timeout: 1'b0}, "t6a");
        check("t6a_no_led", led_seen, 0);

        // Press coincident with the tick that takes the count from 4 to 5.
        start_trial(12'd3);
        wait_led(3);
        repeat (18) @(negedge CLK_50MHZ);
        react_finish('{ms: 14'd5, early: 1'b0, timeout: 1'b0}, "t6b");

        // No press: MAX_MS behaviour.
        start_trial(12'd3);
        wait_led(3);
`ifdef REACTION_TIMEOUT_EN
        begin
            int n;
            sb.push_back('{ms: 14'd9, early: 1'b0, timeout: 1'b1});
            wait_until(W_RV, 80, n);
            check("t3_timeout_latency", n, 36);
            repeat (3) @(negedge CLK_50MHZ);
            check("t3_ms_held", reaction_ms, 9);
            check("t3_timeout_held", timeout, 1);
            check("t3_idle", busy, 0);
        end
`else
        rc0 = result_count;
        repeat (50) @(negedge CLK_50MHZ);
        check("t3_no_result", result_count, rc0);
        check("t3_saturated", reaction_ms, 9);
        check("t3_still_measuring", led_go, 1);
        check("t3_timeout_low", timeout, 0);
        react_finish('{ms: 14'd9, early: 1'b0, timeout: 1'b0}, "t3");
`endif

        // Asynchronous reset in the middle of MEASURE.
        start_trial(12'd3);
        wait_led(3);
        repeat (10) @(negedge CLK_50MHZ);
        check("t5_ms_before_reset", reaction_ms, 2);
        start_btn = 1'b1;
        #2;
        RESET_N = 1'b0;
        #1;
        check("t5_led_go", led_go, 0);
        check("t5_busy", busy, 0);
        check("t5_result_valid", result_valid, 0);
        check("t5_reaction_ms", reaction_ms, 0);
        check("t5_early", early, 0);
        check("t5_timeout", timeout, 0);
        repeat (2) @(negedge CLK_50MHZ);
        RESET_N = 1'b1;
        repeat (6) @(negedge CLK_50MHZ);
        check("t5_held_start_ignored", busy, 0);
        start_btn = 1'b0;
        repeat (2) @(negedge CLK_50MHZ);

        // Recovery trial after reset: shortest delay, one tick of reaction.
        start_trial(12'd0);
        wait_led(0);
        repeat (4) @(negedge CLK_50MHZ);
        react_finish('{ms: 14'd1, early: 1'b0, timeout: 1'b0}, "t5_recover");

        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
